// File: rtl/mem_resp_pkg.sv
// Shared types and default parameters for the mem_responder slice.
package mem_resp_pkg;

  localparam int ADDR_W_DEF      = 8;
  localparam int DATA_W_DEF      = 32;
  localparam int WAIT_CYCLES_DEF = 4;
  localparam int CNT_W           = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_t;

endpackage

// File: rtl/mem_wait_ctr.sv
// Wait-state down-counter: loads on request acceptance, then counts down to zero.
// zero is high when the count is 0 or 1, i.e. the count is zero after the coming edge.
module mem_wait_ctr
  import mem_resp_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count[W-1:1] == '0);

endmodule

// File: rtl/mem_responder.sv
// Single-port memory model answering cache-controller requests after WAIT_CYCLES wait states.
// Optional even-parity protection per word when MEM_RESP_PARITY_EN is defined.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MStrobe,
  input  logic              MRW,
  input  logic [ADDR_W-1:0] MAddr,
  input  logic [DATA_W-1:0] MDataIn,
  output logic [DATA_W-1:0] MDataOut,
  output logic              MReady,
  output logic              MBusy,
  output logic              MParErr
);

`ifdef MEM_RESP_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  state_t            state, state_nxt;
  logic              lat_rw;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              acc_rw;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;
  logic              accept;
  logic              enter_resp;
  logic              cnt_zero;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  rd_word;
  logic [MEM_W-1:0]  mem [2**ADDR_W];

  assign accept = (state == IDLE) && MStrobe;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (MStrobe) state_nxt = (WAIT_CYCLES == 0) ? RESPOND : WAIT;
      WAIT:    if (cnt_zero) state_nxt = RESPOND;
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      lat_rw   <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_rw   <= MRW;
        lat_addr <= MAddr;
        lat_data <= MDataIn;
      end
    end
  end

  mem_wait_ctr #(.W(CNT_W)) u_wait_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (WAIT_LD),
    .zero     (cnt_zero)
  );

  // With zero wait states the response edge is the acceptance edge, so use the live inputs.
  assign acc_rw     = (state == IDLE) ? MRW     : lat_rw;
  assign acc_addr   = (state == IDLE) ? MAddr   : lat_addr;
  assign acc_data   = (state == IDLE) ? MDataIn : lat_data;
  assign enter_resp = (state_nxt == RESPOND);

`ifdef MEM_RESP_PARITY_EN
  assign wr_word = {^acc_data, acc_data};
`else
  assign wr_word = acc_data;
`endif
  assign rd_word = mem[acc_addr];

  // Array is deliberately left out of reset; the reset gate only blocks a commit while held.
  always_ff @(posedge clk) begin
    if (enter_resp && acc_rw && !reset) begin
      mem[acc_addr] <= wr_word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MDataOut <= '0;
    end else if (enter_resp && !acc_rw) begin
      MDataOut <= rd_word[DATA_W-1:0];
    end
  end

`ifdef MEM_RESP_PARITY_EN
  logic par_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_err <= 1'b0;
    end else begin
      par_err <= enter_resp && !acc_rw && (^rd_word);
    end
  end

  assign MParErr = par_err;
`else
  assign MParErr = 1'b0;
`endif

  assign MReady = (state == RESPOND);
  assign MBusy  = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against an array/latency reference model.
// Parity corruption checks compile only when MEM_RESP_PARITY_EN is defined.
module tb_mem_responder;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        strobe = 1'b0, rw = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        ready, busy, perr;

  logic        strobe1 = 1'b0, rw1 = 1'b0;
  logic [7:0]  addr1 = '0;
  logic [31:0] din1 = '0;
  logic [31:0] dout1;
  logic        ready1, busy1, perr1;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [256];
  bit          ref_bad [256];
  logic [31:0] last_rd = '0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(W)) dut0 (
    .clk(clk), .reset(reset), .MStrobe(strobe), .MRW(rw), .MAddr(addr),
    .MDataIn(din), .MDataOut(dout), .MReady(ready), .MBusy(busy), .MParErr(perr)
  );

  mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset), .MStrobe(strobe1), .MRW(rw1), .MAddr(addr1),
    .MDataIn(din1), .MDataOut(dout1), .MReady(ready1), .MBusy(busy1), .MParErr(perr1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One access on dut0; optional noise drives spurious writes to 0x34 while busy.
  task automatic access(input bit w, input logic [7:0] a, input logic [31:0] d, input bit noise);
    int n;
    bit seen, busy_ok;
    @(negedge clk);
    strobe = 1'b1; rw = w; addr = a; din = d;
    n = 0; seen = 0; busy_ok = 1;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      if (ready) seen = 1;
      else if (!busy) busy_ok = 0;
      if (!seen && noise) begin
        strobe = 1'($urandom_range(0, 1));
        rw = 1'b1; addr = 8'h34; din = $urandom;
      end else begin
        strobe = 1'b0;
      end
    end
    check("ready_seen", seen, 1);
    check("latency", n, W + 1);
    check("busy_wait", busy_ok, 1);
    check("busy_respond", busy, 1);
    if (w) begin
      check("dout_hold", dout, last_rd);
      check("perr_write", perr, 0);
      ref_mem[a] = d;
      ref_bad[a] = 0;
    end else begin
      check("rdata", dout, ref_mem[a]);
      check("perr_read", perr, ref_bad[a]);
      last_rd = ref_mem[a];
    end
    @(negedge clk);
    check("ready_pulse", ready, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r[$];
    int idx, lows, cnt;

    repeat (3) @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_perr", perr, 0);
    check("rst_dout", dout, 0);
    check("rst_ready_z", ready1, 0);
    reset = 1'b0;

    // write then read
    access(1, 8'h12, 32'hDEADBEEF, 0);
    access(0, 8'h12, 32'h0, 0);

    // strobes during WAIT must be ignored
    access(1, 8'h34, 32'hCAFEF00D, 0);
    access(0, 8'h12, 32'h0, 1);
    access(1, 8'h13, 32'h01234567, 1);
    access(0, 8'h34, 32'h0, 0);

    // reset two edges into a write aborts it
    access(1, 8'h40, 32'h11111111, 0);
    @(negedge clk);
    strobe = 1'b1; rw = 1'b1; addr = 8'h40; din = 32'hA5A5A5A5;
    @(negedge clk);
    strobe = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_ready", ready, 0);
    check("abort_busy", busy, 0);
    check("abort_dout", dout, 0);
    @(negedge clk);
    reset = 1'b0;
    last_rd = '0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (ready) cnt++;
    end
    check("abort_no_ready", cnt, 0);
    access(0, 8'h40, 32'h0, 0);

    // strobe held high across three reads
    @(negedge clk);
    strobe = 1'b1; rw = 1'b0; addr = 8'h12;
    idx = 0; lows = 0;
    while (r.size() < 3 && idx < 100) begin
      @(negedge clk);
      idx++;
      if (ready) begin
        r.push_back(idx);
        check("held_rdata", dout, ref_mem[8'h12]);
        if (r.size() == 3) strobe = 1'b0;
      end else if (r.size() == 1 && !busy) begin
        lows++;
      end
    end
    last_rd = ref_mem[8'h12];
    check("held_count", r.size(), 3);
    while (r.size() < 3) r.push_back(0);
    check("held_first", r[0], W + 1);
    check("held_gap1", r[1] - r[0], W + 2);
    check("held_gap2", r[2] - r[1], W + 2);
    check("held_busy_low", lows, 1);
    @(negedge clk);

    // randomized traffic over a small address window
    for (int i = 0; i < 16; i++) access(1, 8'(i), $urandom, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 40; i++) begin
      access(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom,
             1'($urandom_range(0, 1)));
    end
    access(0, 8'h34, 32'h0, 0);

    // zero wait states on dut1
    @(negedge clk);
    strobe1 = 1'b1; rw1 = 1'b1; addr1 = 8'h00; din1 = 32'h00000001;
    @(negedge clk);
    strobe1 = 1'b0;
    check("z_wr_ready", ready1, 1);
    check("z_wr_busy", busy1, 1);
    @(negedge clk);
    check("z_wr_pulse", ready1, 0);
    strobe1 = 1'b1; rw1 = 1'b0; addr1 = 8'h00;
    @(negedge clk);
    strobe1 = 1'b0;
    check("z_rd_ready", ready1, 1);
    check("z_rd_data", dout1, 32'h00000001);
    check("z_rd_perr", perr1, 0);
    @(negedge clk);
    check("z_rd_pulse", ready1, 0);

`ifdef MEM_RESP_PARITY_EN
    access(1, 8'h07, 32'h12345678, 0);
    access(1, 8'h08, 32'h9ABCDEF0, 0);
    @(negedge clk);
    dut0.mem[7] = dut0.mem[7] ^ 33'h1_0000_0000;
    ref_bad[7] = 1;
    access(0, 8'h07, 32'h0, 0);
    access(0, 8'h08, 32'h0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
